lsu_wb_stage: RTL

- Memory-access and writeback stage, directly downstream of the execute stage in the pd-series RISC-V core.
- Accepts one retired-execute bundle at a time over a valid/ready handshake: ALU result, rs2 data, PC and control bits.
- Performs loads and stores against a data memory through a req/gnt/rvalid port, which tolerates variable grant and read latency.
- Aligns and extends load data, selects the writeback source, and emits a one-cycle writeback pulse to the register file.

---
 rtl/lsu_wb_stage_if.sv | 52 +++++
 rtl/lsu_wb_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage_if.sv
// Bundle of the execute-side handshake, data-memory port and writeback port
// of the memory/writeback stage. The stage connects through the slave modport.
interface lsu_wb_stage_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  // Execute bundle
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [AWIDTH-1:0] ex_pc_i;
  logic [DWIDTH-1:0] ex_alu_res_i;
  logic [DWIDTH-1:0] ex_rs2data_i;
  logic [2:0]        ex_funct3_i;
  logic [4:0]        ex_rd_i;
  logic              ex_regwren_i;
  logic              ex_memren_i;
  logic              ex_memwren_i;
  logic [1:0]        ex_wbsel_i;
  // Data memory port
  logic              dmem_req_o;
  logic              dmem_gnt_i;
  logic              dmem_we_o;
  logic [AWIDTH-1:0] dmem_addr_o;
  logic [DWIDTH-1:0] dmem_wdata_o;
  logic [3:0]        dmem_be_o;
  logic              dmem_rvalid_i;
  logic [DWIDTH-1:0] dmem_rdata_i;
  // Writeback port
  logic              wb_valid_o;
  logic              wb_regwren_o;
  logic [4:0]        wb_rd_o;
  logic [DWIDTH-1:0] wb_data_o;
  logic              fault_o;

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_alu_res_i, ex_rs2data_i, ex_funct3_i, ex_rd_i,
    input  ex_regwren_i, ex_memren_i, ex_memwren_i, ex_wbsel_i,
    output ex_ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output wb_valid_o, wb_regwren_o, wb_rd_o, wb_data_o, fault_o
  );

  modport master (
    output ex_valid_i, ex_pc_i, ex_alu_res_i, ex_rs2data_i, ex_funct3_i, ex_rd_i,
    output ex_regwren_i, ex_memren_i, ex_memwren_i, ex_wbsel_i,
    input  ex_ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  wb_valid_o, wb_regwren_o, wb_rd_o, wb_data_o, fault_o
  );
endinterface

// File: rtl/lsu_wb_stage.sv
// Memory-access and writeback stage: takes one execute bundle at a time,
// performs the load/store over a req/gnt/rvalid port, and emits a one-cycle
// writeback pulse with aligned/extended data.
module lsu_wb_stage #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  lsu_wb_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] alu_q, rs2_q, rdata_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              regwren_q, store_q, fault_q;
  logic [1:0]        wbsel_q;

  logic accept, acc_mem, acc_fault;
  logic [1:0] byte_off;
  logic [DWIDTH-1:0] load_shift, load_data;
  logic [AWIDTH-1:0] pc_plus4;

  assign accept   = bus.ex_valid_i && (state_q == StIdle);
  assign acc_mem  = bus.ex_memren_i || bus.ex_memwren_i;
  assign byte_off = alu_q[1:0];

  // Legality/alignment check of the incoming op; memwren wins over memren.
  always_comb begin
    acc_fault = 1'b0;
    if (bus.ex_memwren_i) begin
      unique case (bus.ex_funct3_i)
        3'b000:  acc_fault = 1'b0;
        3'b001:  acc_fault = bus.ex_alu_res_i[0];
        3'b010:  acc_fault = (bus.ex_alu_res_i[1:0] != 2'b00);
        default: acc_fault = 1'b1;
      endcase
    end else if (bus.ex_memren_i) begin
      unique case (bus.ex_funct3_i)
        3'b000, 3'b100: acc_fault = 1'b0;
        3'b001, 3'b101: acc_fault = bus.ex_alu_res_i[0];
        3'b010:         acc_fault = (bus.ex_alu_res_i[1:0] != 2'b00);
        default:        acc_fault = 1'b1;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (acc_mem && !acc_fault) ? StReq : StDone;
      StReq:  if (bus.dmem_gnt_i) state_d = store_q ? StDone : StWait;
      StWait: if (bus.dmem_rvalid_i) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register plus bundle capture at accept and read data capture in wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      alu_q     <= '0;
      rs2_q     <= '0;
      rdata_q   <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      regwren_q <= 1'b0;
      store_q   <= 1'b0;
      fault_q   <= 1'b0;
      wbsel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q      <= bus.ex_pc_i;
        alu_q     <= bus.ex_alu_res_i;
        rs2_q     <= bus.ex_rs2data_i;
        funct3_q  <= bus.ex_funct3_i;
        rd_q      <= bus.ex_rd_i;
        regwren_q <= bus.ex_regwren_i;
        store_q   <= bus.ex_memwren_i;
        fault_q   <= acc_fault;
        wbsel_q   <= bus.ex_wbsel_i;
      end
      if (state_q == StWait && bus.dmem_rvalid_i) rdata_q <= bus.dmem_rdata_i;
    end
  end

  // Memory request: driven purely from captured state so it holds until grant.
  always_comb begin
    bus.dmem_req_o   = (state_q == StReq);
    bus.dmem_we_o    = store_q;
    bus.dmem_addr_o  = alu_q[AWIDTH-1:0] & ~AWIDTH'(3);
    bus.dmem_wdata_o = rs2_q;
    bus.dmem_be_o    = 4'b1111;
    if (store_q) begin
      unique case (funct3_q[1:0])
        2'b00: begin
          bus.dmem_wdata_o = {4{rs2_q[7:0]}};
          bus.dmem_be_o    = 4'b0001 << byte_off;
        end
        2'b01: begin
          bus.dmem_wdata_o = {2{rs2_q[15:0]}};
          bus.dmem_be_o    = 4'b0011 << byte_off;
        end
        default: begin
          bus.dmem_wdata_o = rs2_q;
          bus.dmem_be_o    = 4'b1111;
        end
      endcase
    end
  end

  // Load alignment and extension, then writeback source select.
  always_comb begin
    load_shift = rdata_q >> {byte_off, 3'b000};
    unique case (funct3_q)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'd0, load_shift[7:0]};
      3'b101:  load_data = {16'd0, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
    pc_plus4 = pc_q + AWIDTH'(4);
    unique case (wbsel_q)
      2'd1:    bus.wb_data_o = load_data;
      2'd2:    bus.wb_data_o = DWIDTH'(pc_plus4);
      default: bus.wb_data_o = alu_q;
    endcase
  end

  assign bus.ex_ready_o   = (state_q == StIdle);
  assign bus.wb_valid_o   = (state_q == StDone);
  assign bus.wb_rd_o      = rd_q;
  assign bus.wb_regwren_o = regwren_q && (rd_q != 5'd0) && !fault_q && !store_q;
  assign bus.fault_o      = fault_q;

endmodule
